// File: rtl/fib_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fib_sequencer
// Description : Moore controller that drives a 4-entry register file and
//               adder to compute F(n) mod 2^REGF_WIDTH with overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_sequencer #(
   parameter int REGF_WIDTH = 16,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  n,
   input  logic [REGF_WIDTH-1:0] reg1,
   input  logic [REGF_WIDTH-1:0] reg2,
   output logic [1:0]            write,
   output logic [1:0]            read1,
   output logic [1:0]            read2,
   output logic [REGF_WIDTH-1:0] data_out,
   output logic                  busy,
   output logic                  done,
   output logic [REGF_WIDTH-1:0] result,
   output logic                  overflow
);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_INIT0  = 3'd1;
   localparam logic [2:0] c_INIT1  = 3'd2;
   localparam logic [2:0] c_ADD    = 3'd3;
   localparam logic [2:0] c_MOV1   = 3'd4;
   localparam logic [2:0] c_MOV2   = 3'd5;
   localparam logic [2:0] c_FINISH = 3'd6;

   localparam logic [CNT_WIDTH-1:0]  c_CNT_ZERO = '0;
   localparam logic [CNT_WIDTH-1:0]  c_CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [REGF_WIDTH-1:0] c_DATA_ONE = REGF_WIDTH'(1);

   logic [2:0]            r_state;
   logic [2:0]            w_next;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic                  r_ovf_acc;
   logic [REGF_WIDTH-1:0] r_result;
   logic                  r_overflow;
   logic                  r_done;
   logic [REGF_WIDTH:0]   w_sum;

   assign w_sum    = {1'b0, reg1} + {1'b0, reg2};
   assign busy     = (r_state != c_IDLE);
   assign done     = r_done;
   assign result   = r_result;
   assign overflow = r_overflow;

   always_comb begin
      w_next   = r_state;
      write    = 2'b00;
      read1    = 2'b00;
      read2    = 2'b00;
      data_out = '0;
      case (r_state)
         c_IDLE: begin
            if (start) w_next = c_INIT0;
         end
         c_INIT0: begin
            write  = 2'b01;
            w_next = c_INIT1;
         end
         c_INIT1: begin
            write    = 2'b10;
            data_out = c_DATA_ONE;
            w_next   = (r_cnt == c_CNT_ZERO) ? c_FINISH : c_ADD;
         end
         c_ADD: begin
            read1    = 2'b01;
            read2    = 2'b10;
            write    = 2'b11;
            data_out = w_sum[REGF_WIDTH-1:0];
            w_next   = c_MOV1;
         end
         c_MOV1: begin
            read1    = 2'b10;
            write    = 2'b01;
            data_out = reg1;
            w_next   = c_MOV2;
         end
         c_MOV2: begin
            read1    = 2'b11;
            write    = 2'b10;
            data_out = reg1;
            w_next   = (r_cnt == c_CNT_ONE) ? c_FINISH : c_ADD;
         end
         c_FINISH: begin
            read1  = 2'b01;
            w_next = c_IDLE;
         end
         default: w_next = c_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= c_IDLE;
         r_cnt      <= '0;
         r_ovf_acc  <= 1'b0;
         r_result   <= '0;
         r_overflow <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_cnt     <= n;
                  r_ovf_acc <= 1'b0;
               end
            end
            // Carry on the final iteration belongs to F(n+1), so it is ignored.
            c_ADD: begin
               if (w_sum[REGF_WIDTH] && (r_cnt > c_CNT_ONE)) r_ovf_acc <= 1'b1;
            end
            c_MOV2: r_cnt <= r_cnt - c_CNT_ONE;
            c_FINISH: begin
               r_result   <= reg1;
               r_overflow <= r_ovf_acc;
               r_done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fib_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_sequencer
// Description : Directed self-checking bench for fib_sequencer with a
//               behavioural 4-entry register file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  n;
   logic [15:0] reg1;
   logic [15:0] reg2;
   logic [1:0]  write;
   logic [1:0]  read1;
   logic [1:0]  read2;
   logic [15:0] data_out;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        overflow;

   logic [15:0] rf [0:3];
   logic        rf_init;

   int vectors    = 0;
   int miscompares = 0;

   logic [1:0] wseq [0:255];
   int         wcount;
   int         lat;
   logic       busy_ok;

   fib_sequencer #(.REGF_WIDTH(16), .CNT_WIDTH(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .n        (n),
      .reg1     (reg1),
      .reg2     (reg2),
      .write    (write),
      .read1    (read1),
      .read2    (read2),
      .data_out (data_out),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file: R0 reads zero, writes land on the rising edge.
   always @(posedge clk) begin
      if (rf_init) begin
         rf[0] <= 16'h0000;
         rf[1] <= 16'h1111;
         rf[2] <= 16'h2222;
         rf[3] <= 16'h3333;
      end else if (write != 2'b00) begin
         rf[write] <= data_out;
      end
   end
   assign reg1 = (read1 == 2'b00) ? 16'h0000 : rf[read1];
   assign reg2 = (read2 == 2'b00) ? 16'h0000 : rf[read2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_outs"}, {write, read1, read2, data_out, busy, done, overflow}, 32'd0);
      check({tag, "_result"}, {16'd0, result}, 32'd0);
   endtask

   // Called at #1 after E0; returns in the done cycle (or after the budget).
   task automatic wait_done(input int max_cycles, input logic hold_start);
      lat     = 0;
      wcount  = 0;
      busy_ok = 1'b1;
      while (!done && lat < max_cycles) begin
         if (wcount < 256) wseq[wcount] = write;
         wcount++;
         if (!busy) busy_ok = 1'b0;
         if (hold_start) n = 8'($urandom);
         tick();
         lat++;
      end
      if (!done) check("timeout_waiting_done", {31'd0, done}, 32'd1);
   endtask

   task automatic run(input string tag, input logic [7:0] nn,
                      input logic [15:0] exp_res, input logic exp_ovf);
      int exp_lat;
      exp_lat = 3 * int'(nn) + 3;
      start = 1'b1;
      n     = nn;
      tick();
      start = 1'b0;
      n     = 8'hFF;
      wait_done(exp_lat + 20, 1'b0);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
      check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
      check({tag, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
      check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
      tick();
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_result_hold"}, {16'd0, result}, {16'd0, exp_res});
   endtask

   initial begin
      reset   = 1'b0;
      start   = 1'b0;
      n       = 8'd0;
      rf_init = 1'b1;
      #1;
      check_reset_outputs("reset");
      tick();
      rf_init = 1'b0;
      tick();
      reset = 1'b1;

      begin
         logic wr_quiet;
         wr_quiet = 1'b1;
         for (int i = 0; i < 5; i++) begin
            tick();
            if (write != 2'b00 || busy || done) wr_quiet = 1'b0;
         end
         check("idle_quiet", {31'd0, wr_quiet}, 32'd1);
         check("idle_rf", {rf[1], rf[2]}, {16'h1111, 16'h2222});
         check("idle_rf3", {16'd0, rf[3]}, 32'h3333);
      end

      run("n0", 8'd0, 16'd0, 1'b0);
      run("n1", 8'd1, 16'd1, 1'b0);

      run("n10", 8'd10, 16'd55, 1'b0);
      begin
         logic seq_ok;
         logic [1:0] exp_w;
         seq_ok = (wcount == 33);
         for (int k = 0; k < 33 && k < wcount; k++) begin
            if (k == 0)       exp_w = 2'b01;
            else if (k == 1)  exp_w = 2'b10;
            else if (k == 32) exp_w = 2'b00;
            else case ((k - 2) % 3)
               0:       exp_w = 2'b11;
               1:       exp_w = 2'b01;
               default: exp_w = 2'b10;
            endcase
            if (wseq[k] !== exp_w) seq_ok = 1'b0;
         end
         check("n10_write_seq", {31'd0, seq_ok}, 32'd1);
      end

      run("n24", 8'd24, 16'd46368, 1'b0);
      run("n25", 8'd25, 16'd9489, 1'b1);

      // start held high for the whole n=5 run, then n=7 in the done cycle
      start = 1'b1;
      n     = 8'd5;
      tick();
      wait_done(40, 1'b1);
      check("hold_latency", lat, 18);
      check("hold_result", {16'd0, result}, 32'd5);
      n = 8'd7;
      tick();
      start = 1'b0;
      n     = 8'd0;
      wait_done(60, 1'b0);
      check("done_start_latency", lat, 24);
      check("done_start_result", {16'd0, result}, 32'd13);
      tick();

      // asynchronous reset in the third ADD state of an n=20 run
      start = 1'b1;
      n     = 8'd20;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("third_add_write", {30'd0, write}, 32'd3);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("midrun_reset");
      tick();
      check_reset_outputs("midrun_reset_held");
      reset = 1'b1;
      tick();
      run("n6_after_reset", 8'd6, 16'd8, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
